// File: rtl/zlib_wrap_ctrl.sv
// zlib stream wrapper: header, payload pass-through to adler32,
// then big-endian checksum trailer from a single output register.
module zlib_wrap_ctrl #(
  parameter int          DATA_WD  = 32,
  parameter int          NUM_WD   = 2,
  parameter logic [15:0] ZLIB_HDR = 16'h7801
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic               val_i,
  input  logic [DATA_WD-1:0] dat_i,
  input  logic [NUM_WD-1:0]  num_i,
  input  logic               lst_i,
  output logic               rdy_o,
  output logic               adl_start_o,
  output logic               adl_val_o,
  output logic [DATA_WD-1:0] adl_dat_o,
  output logic [NUM_WD-1:0]  adl_num_o,
  output logic               adl_lst_o,
  input  logic               adl_done_i,
  input  logic               adl_val_i,
  input  logic [DATA_WD-1:0] adl_dat_i,
  output logic               val_o,
  output logic [DATA_WD-1:0] dat_o,
  output logic [NUM_WD-1:0]  num_o,
  output logic               lst_o,
  input  logic               rdy_i,
  output logic               done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_DATA,
    S_WAIT,
    S_TAIL,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               val_q, val_d;
  logic [DATA_WD-1:0] dat_q, dat_d;
  logic [NUM_WD-1:0]  num_q, num_d;
  logic               lst_q, lst_d;
  logic [DATA_WD-1:0] csum_q, csum_d;
  logic               csum_vld_q, csum_vld_d;
  logic               adl_start_q, adl_start_d;

  logic               xfer;
  logic               free;
  logic               acc;
  logic               unused_adl_done;

  // completion of the engine is implied by its checksum strobe
  assign unused_adl_done = adl_done_i;

  assign xfer = val_q & rdy_i;
  assign free = ~val_q | rdy_i;
  assign acc  = (state_q == S_DATA) & val_i & free;

  assign val_o       = val_q;
  assign dat_o       = dat_q;
  assign num_o       = num_q;
  assign lst_o       = lst_q;
  assign adl_start_o = adl_start_q;

  // payload mirror to the adler32 engine, zero unless a word is accepted
  always_comb begin
    adl_val_o = acc;
    adl_dat_o = '0;
    adl_num_o = '0;
    adl_lst_o = 1'b0;
    if (acc) begin
      adl_dat_o = dat_i;
      adl_num_o = num_i;
      adl_lst_o = lst_i;
    end
  end

  // sequencing and output-register next state
  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    dat_d       = dat_q;
    num_d       = num_q;
    lst_d       = lst_q;
    csum_d      = csum_q;
    csum_vld_d  = csum_vld_q;
    adl_start_d = 1'b0;
    rdy_o       = 1'b0;
    done_o      = 1'b0;

    if (xfer) begin
      val_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_HEAD;
          adl_start_d = 1'b1;
          val_d       = 1'b1;
          dat_d       = {ZLIB_HDR, {(DATA_WD-16){1'b0}}};
          num_d       = NUM_WD'(1);
          lst_d       = 1'b0;
          csum_vld_d  = 1'b0;
        end
      end
      S_HEAD: begin
        if (xfer) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        rdy_o = free;
        if (acc) begin
          val_d = 1'b1;
          dat_d = dat_i;
          num_d = num_i;
          lst_d = 1'b0;
          if (lst_i) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (adl_val_i && !csum_vld_q) begin
          csum_d     = adl_dat_i;
          csum_vld_d = 1'b1;
        end
        if (csum_vld_q && free) begin
          state_d = S_TAIL;
          val_d   = 1'b1;
          dat_d   = csum_q;
          num_d   = NUM_WD'(3);
          lst_d   = 1'b1;
        end
      end
      S_TAIL: begin
        if (xfer) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      val_q       <= 1'b0;
      dat_q       <= '0;
      num_q       <= '0;
      lst_q       <= 1'b0;
      csum_q      <= '0;
      csum_vld_q  <= 1'b0;
      adl_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      dat_q       <= dat_d;
      num_q       <= num_d;
      lst_q       <= lst_d;
      csum_q      <= csum_d;
      csum_vld_q  <= csum_vld_d;
      adl_start_q <= adl_start_d;
    end
  end

endmodule

// File: tb/tb_zlib_wrap_ctrl.sv
// Bench for zlib_wrap_ctrl: directed streams, scoreboard queues,
// a stand-in adler32 engine returning hand-computed checksums.
module tb_zlib_wrap_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i = 1'b0;
  logic        val_i = 1'b0;
  logic [31:0] dat_i = '0;
  logic [1:0]  num_i = '0;
  logic        lst_i = 1'b0;
  logic        rdy_o;
  logic        adl_start_o;
  logic        adl_val_o;
  logic [31:0] adl_dat_o;
  logic [1:0]  adl_num_o;
  logic        adl_lst_o;
  logic        adl_done_i = 1'b0;
  logic        adl_val_i = 1'b0;
  logic [31:0] adl_dat_i = '0;
  logic        val_o;
  logic [31:0] dat_o;
  logic [1:0]  num_o;
  logic        lst_o;
  logic        rdy_i = 1'b1;
  logic        done_o;

  zlib_wrap_ctrl dut (
    .clk(clk), .rstn(rstn), .start_i(start_i),
    .val_i(val_i), .dat_i(dat_i), .num_i(num_i),
    .lst_i(lst_i), .rdy_o(rdy_o),
    .adl_start_o(adl_start_o), .adl_val_o(adl_val_o),
    .adl_dat_o(adl_dat_o), .adl_num_o(adl_num_o),
    .adl_lst_o(adl_lst_o), .adl_done_i(adl_done_i),
    .adl_val_i(adl_val_i), .adl_dat_i(adl_dat_i),
    .val_o(val_o), .dat_o(dat_o), .num_o(num_o),
    .lst_o(lst_o), .rdy_i(rdy_i), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  n;
    logic        l;
  } ent_t;

  ent_t        out_q[$];
  ent_t        adl_q[$];
  int          errs = 0;
  int          checks = 0;
  int          start_cnt = 0;
  int          done_cnt = 0;
  int          rdy_mode = 0;
  int          adl_dly = 1;
  int          pend = -1;
  logic [31:0] adl_csum = '0;
  logic [31:0] wd[4];
  logic [1:0]  wn[4];

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // downstream ready pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rdy_i = 1'b1;
        1:       rdy_i = ~rdy_i;
        default: rdy_i = 1'b0;
      endcase
    end
  end

  // stand-in adler32: one-cycle checksum strobe adl_dly cycles after lst
  initial begin
    logic fire;
    logic live;
    forever begin
      @(posedge clk);
      fire = adl_val_o & adl_lst_o;
      live = rstn;
      #1;
      adl_val_i = 1'b0;
      if (!live) pend = -1;
      else if (fire) pend = adl_dly;
      else if (pend > 0) pend--;
      if (pend == 0) begin
        adl_val_i = 1'b1;
        adl_dat_i = adl_csum;
        pend = -1;
      end
    end
  end

  // monitor: pops expected words whenever the DUT presents them
  initial begin
    logic        held;
    logic [35:0] hold_v;
    ent_t        e;
    held = 1'b0;
    hold_v = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        held = 1'b0;
      end else begin
        if (adl_start_o) begin
          start_cnt++;
          chk("adl_start_excl", {63'd0, adl_val_o}, 64'd0);
        end
        if (done_o) done_cnt++;
        if (held)
          chk("hold_stable", {28'd0, val_o, dat_o, num_o, lst_o},
              {28'd0, hold_v});
        if (val_o && !rdy_i)
          chk("rdy_o_stall", {63'd0, rdy_o}, 64'd0);
        if (val_o && rdy_i) begin
          if (out_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL out_extra: got %0h expected none",
                     {dat_o, num_o, lst_o});
          end else begin
            e = out_q.pop_front();
            chk("out_word", {29'd0, dat_o, num_o, lst_o},
                {29'd0, e});
          end
        end
        if (adl_val_o) begin
          if (adl_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL adl_extra: got %0h expected none",
                     {adl_dat_o, adl_num_o, adl_lst_o});
          end else begin
            e = adl_q.pop_front();
            chk("adl_word",
                {29'd0, adl_dat_o, adl_num_o, adl_lst_o},
                {29'd0, e});
          end
        end else begin
          chk("adl_idle_zero",
              {29'd0, adl_dat_o, adl_num_o, adl_lst_o}, 64'd0);
        end
        held = val_o & ~rdy_i;
        hold_v = {val_o, dat_o, num_o, lst_o};
      end
    end
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [1:0] n,
                           input logic l, input logic hold);
    logic got;
    got = 1'b0;
    out_q.push_back({d, n, 1'b0});
    adl_q.push_back({d, n, l});
    if (l) out_q.push_back({adl_csum, 2'd3, 1'b1});
    val_i = 1'b1;
    dat_i = d;
    num_i = n;
    lst_i = l;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rdy_o) begin
        got = 1'b1;
        if (l && hold) rdy_mode = 2;
        break;
      end
    end
    @(posedge clk);
    #1;
    val_i = 1'b0;
    lst_i = 1'b0;
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_stream(input int nw, input logic [31:0] csum,
                            input int dly, input logic mid,
                            input logic hold);
    int s0;
    int d0;
    s0 = start_cnt;
    d0 = done_cnt;
    adl_csum = csum;
    adl_dly = dly;
    out_q.push_back({32'h78010000, 2'd1, 1'b0});
    pulse_start();
    for (int i = 0; i < nw; i++) begin
      send_word(wd[i], wn[i], (i == nw - 1), hold);
      if (mid && i == 0 && nw > 1) pulse_start();
    end
    if (hold) begin
      repeat (6) @(posedge clk);
      rdy_mode = 0;
    end
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("start_pulses", 64'(start_cnt - s0), 64'd1);
    chk("out_drained", 64'(out_q.size()), 64'd0);
    chk("adl_drained", 64'(adl_q.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_val_o", {63'd0, val_o}, 64'd0);
    chk("rst_dat_o", {32'd0, dat_o}, 64'd0);
    chk("rst_rdy_o", {63'd0, rdy_o}, 64'd0);
    chk("rst_done_o", {63'd0, done_o}, 64'd0);
    chk("rst_adl_start", {63'd0, adl_start_o}, 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // spurious payload while idle
    val_i = 1'b1;
    dat_i = 32'hDEADBEEF;
    num_i = 2'd3;
    lst_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rdy_o", {63'd0, rdy_o}, 64'd0);
      chk("idle_val_o", {63'd0, val_o}, 64'd0);
    end
    @(posedge clk);
    #1;
    val_i = 1'b0;
    lst_i = 1'b0;

    // one-word stream, Adler32(04 09 04 09) = 0040001B
    wd[0] = 32'h04090409; wn[0] = 2'd3;
    run_stream(1, 32'h0040001B, 1, 1'b0, 1'b0);

    // two words 01..05, Adler32 = 00280010; stray start mid-stream
    wd[0] = 32'h01020304; wn[0] = 2'd3;
    wd[1] = 32'h05000000; wn[1] = 2'd0;
    run_stream(2, 32'h00280010, 2, 1'b1, 1'b0);

    // alternating stalls, bytes 00 00 00 01 00 02 00 -> 000F0004
    rdy_mode = 1;
    wd[0] = 32'h00000001; wn[0] = 2'd3;
    wd[1] = 32'h00000000; wn[1] = 2'd0;
    wd[2] = 32'h02000000; wn[2] = 2'd1;
    run_stream(3, 32'h000F0004, 0, 1'b0, 1'b0);
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // checksum arrives while the last payload word is stalled
    wd[0] = 32'h01000000; wn[0] = 2'd0;
    run_stream(1, 32'h00020002, 0, 1'b0, 1'b1);

    // reset while waiting for the checksum
    adl_csum = 32'hFFFFFFFF;
    adl_dly = 40;
    out_q.push_back({32'h78010000, 2'd1, 1'b0});
    pulse_start();
    send_word(32'h04090409, 2'd3, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("wrst_val_o", {63'd0, val_o}, 64'd0);
    chk("wrst_dat_o", {32'd0, dat_o}, 64'd0);
    chk("wrst_num_lst", {61'd0, num_o, lst_o}, 64'd0);
    chk("wrst_rdy_o", {63'd0, rdy_o}, 64'd0);
    chk("wrst_done_o", {63'd0, done_o}, 64'd0);
    chk("wrst_adl", {62'd0, adl_start_o, adl_val_o}, 64'd0);
    out_q.delete();
    adl_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    wd[0] = 32'h04090409; wn[0] = 2'd3;
    run_stream(1, 32'h0040001B, 3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
